// File: rtl/regwrite_arbiter_wb.sv
// Write-back arbiter for the ID-stage register file write port.
// Merges the WB-stage main write with side-datapath writes queued in a
// small FIFO, and reports pending writes to the ID read addresses so ID
// can stall on read-after-write hazards.
module regwrite_arbiter_wb #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MainRegWrite,
  input  logic [ADDR_W-1:0] MainWriteRegister,
  input  logic [DATA_W-1:0] MainWriteData,
  input  logic              SideValid,
  input  logic [ADDR_W-1:0] SideRegister,
  input  logic [DATA_W-1:0] SideData,
  output logic              SideReady,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic main_live;
  logic push;
  logic pop;
  logic hit1;
  logic hit2;

  // Full check uses start-of-cycle count, so a same-cycle pop never frees a slot.
  assign SideReady = !Rst && (count < CNT_W'(DEPTH));
  assign Empty     = (count == '0);

  // Main writes to r0 are dropped; side writes to r0 are acknowledged but not queued.
  assign main_live = MainRegWrite && (MainWriteRegister != '0);
  assign push      = SideValid && SideReady && (SideRegister != '0);
  assign pop       = !main_live && (count != '0);

  // Control state: pointers, occupancy, entry valid flags and the output register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_vld      <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Push and pop never target the same slot: that needs a full FIFO
      // (no push) or an empty one (no pop).
      if (pop)  fifo_vld[rd_ptr] <= 1'b0;
      if (push) fifo_vld[wr_ptr] <= 1'b1;

      // Main write has priority; the FIFO only drains on main-idle cycles.
      if (main_live) begin
        RegWrite      <= 1'b1;
        WriteRegister <= MainWriteRegister;
        WriteData     <= MainWriteData;
      end else if (pop) begin
        RegWrite      <= 1'b1;
        WriteRegister <= fifo_addr[rd_ptr];
        WriteData     <= fifo_data[rd_ptr];
      end else begin
        RegWrite      <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are only meaningful where fifo_vld is set.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= SideRegister;
      fifo_data[wr_ptr] <= SideData;
    end
  end

  // Hazard flags: any queued entry or the in-flight output write targets the read address.
  always_comb begin
    hit1 = RegWrite && (WriteRegister == ReadRegister1);
    hit2 = RegWrite && (WriteRegister == ReadRegister2);
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (fifo_addr[i] == ReadRegister1)) hit1 = 1'b1;
      if (fifo_vld[i] && (fifo_addr[i] == ReadRegister2)) hit2 = 1'b1;
    end
    Busy1 = hit1 && (ReadRegister1 != '0);
    Busy2 = hit2 && (ReadRegister2 != '0);
  end

endmodule

// File: doc/regwrite_arbiter_wb.md
# regwrite_arbiter_wb

Write-back arbiter that drives the single write port of the ID-stage register file (WriteRegister / WriteData / RegWrite). It merges the main pipeline's WB-stage write with register updates from the SAD side datapath (sad, x, y, iterator results), buffering side writes in a small FIFO so neither source is lost. It also flags pending writes to the registers being read, so ID can stall on read-after-write hazards.

## Interface
Parameters:
- DEPTH, 4, side-write FIFO entries (power of 2, ≥2)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  reset; asynchronous, active-high
- MainRegWrite  input  1  WB-stage write request
- MainWriteRegister  input  ADDR_W  WB-stage destination register
- MainWriteData  input  DATA_W  WB-stage write data
- SideValid  input  1  side-datapath write request
- SideRegister  input  ADDR_W  side destination register
- SideData  input  DATA_W  side write data
- SideReady  output  1  side request accepted this cycle when SideValid && SideReady
- ReadRegister1  input  ADDR_W  ID read address for hazard check
- ReadRegister2  input  ADDR_W  ID read address for hazard check
- RegWrite  output  1  to register file write enable (registered)
- WriteRegister  output  ADDR_W  to register file (registered)
- WriteData  output  DATA_W  to register file (registered)
- Busy1  output  1  ReadRegister1 has a pending buffered write
- Busy2  output  1  ReadRegister2 has a pending buffered write
- Empty  output  1  FIFO holds no entries

## Operation
- Main write is "live" when MainRegWrite=1 and MainWriteRegister≠0. Main writes are never buffered and never refused.
- Side push: occurs when SideValid && SideReady. SideRegister=0 is handshaken but discarded (no entry, no count change).
- SideReady = !Rst && (count < DEPTH); computed from start-of-cycle count. No push-through: when the FIFO is full, SideReady=0 even if a pop occurs in the same cycle.
- Output selection each cycle, priority order: live main write; else FIFO head (pop); else idle (RegWrite=0, WriteRegister/WriteData hold their previous values).
- Push and pop in the same cycle are both legal; count is unchanged.
- The FIFO drains only on cycles without a live main write. Starvation under back-to-back main writes is permitted; backpressure via SideReady is the only protection.
- Busy1 = ReadRegisterN≠0 and matches the address of any valid FIFO entry or the output register while RegWrite=1. Busy2 is the same check on ReadRegister2. Both are combinational from state, not from the same-cycle Side inputs.
- Ordering: side writes leave in acceptance order. A main write to the same register overtakes queued side writes to that register; the later side write wins, by design.
- count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync release): RegWrite=0, WriteRegister=0, WriteData=0, count=0, pointers=0, Empty=1, Busy1=Busy2=0, SideReady=0 while Rst=1.
- Reset mid-operation: all queued entries are dropped. No write is issued on the edge where reset deasserts.
- Main latency: 1 cycle. Inputs are sampled at edge N, and RegWrite/WriteRegister/WriteData are valid after edge N. The register file commits at edge N+1.
- Side minimum latency: 2 cycles. Push at edge N, pop to the output register at edge N+1 if no live main write at that edge.
- Throughput: one register-file write per cycle. A sustained side rate of 1/cycle is possible only with no main writes.
- Empty updates on the same edge as count.

## Test plan
- Reset, then main write r9=0x0000_0010 -> one cycle later RegWrite=1, WriteRegister=9, WriteData=0x10. Following idle cycle RegWrite=0.
- Four side pushes (r16..r19 = 1..4) while MainRegWrite held 1 to r8 -> SideReady drops after the 4th push. Fifth push stalls. After main is released, writes emerge r16,r17,r18,r19 on consecutive cycles, then SideReady=1 and Empty=1.
- Same-cycle main r5=0xA and side r17=0xB -> output r5 first, r17 on the next cycle. Busy1=1 for ReadRegister1=17 until r17 has left the output register.
- Side push to r0 with data 0xFFFF_FFFF -> handshaken, count stays 0, RegWrite never asserts for it. Main write to r0 -> RegWrite stays 0.
- FIFO full with a simultaneous pop -> SideReady=0 that cycle, count goes 4→3, and SideReady=1 on the next cycle.
- Assert Rst asynchronously with 3 queued entries mid-cycle -> outputs go to zero immediately. After release, no queued write appears and Empty=1.
